// File: rtl/fifo_sig_ram_pkg.sv
// Shared constants, grant/preference types and pointer helper for the
// single-port-RAM FIFO controller.
package fifo_sig_ram_pkg;

    localparam int OB_DEPTH   = 3;
    localparam int RAM_RD_LAT = 1;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } gnt_e;

    typedef enum logic {
        PREF_WR = 1'b0,
        PREF_RD = 1'b1
    } pref_e;

    // Increment a RAM pointer, wrapping DEPTH-1 -> 0 (DEPTH need not be 2^n).
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_sig_ram_obuf.sv
// 3-entry in-order register FIFO that holds words read back from the RAM;
// head is registered so out_data never comes straight from the RAM.
module fifo_sig_ram_obuf
    import fifo_sig_ram_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       cnt
);

    logic [WIDTH-1:0] mem [OB_DEPTH];
    logic [1:0]       wr_idx;

    // A simultaneous pop shifts everything down, so the push lands one slot lower.
    assign wr_idx = cnt - 2'(pop);
    assign head   = mem[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            for (int i = 0; i < OB_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop) begin
                for (int i = 0; i < OB_DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
            end
            if (push) begin
                mem[wr_idx] <= push_data;
            end
            cnt <= cnt + 2'(push) - 2'(pop);
        end
    end

endmodule

// File: rtl/fifo_sig_ram_ctrl.sv
// Controller that turns a one-op-per-cycle single-port RAM into a valid/ready
// FIFO: arbitrates pushes against prefetch reads and hides the read latency.
module fifo_sig_ram_ctrl
    import fifo_sig_ram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 128
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+4)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         ram_wren,
    output logic [$clog2(DEPTH)-1:0]     ram_addr,
    output logic [WIDTH-1:0]             ram_data_in,
    input  logic [WIDTH-1:0]             ram_data_out
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 4);

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         ram_count;
    logic [RAM_RD_LAT-1:0] rd_inflight;
    logic [1:0]            ob_cnt;
    pref_e                 pref;
    gnt_e                  gnt;
    logic                  read_want;
    logic                  contended;
    logic                  pop;

    // Both ports are valid/ready: a word moves on a rising edge where
    // valid && ready; ready is built from registered state only.
    assign read_want = (ram_count != '0) &&
                       ((int'(ob_cnt) + int'(rd_inflight)) < OB_DEPTH);
    assign full      = (ram_count == CW'(DEPTH));
    assign in_ready  = rst_n && !full && !(read_want && pref == PREF_RD);
    assign contended = rst_n && read_want && in_valid && !full;

    always_comb begin
        gnt = GNT_IDLE;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                gnt = GNT_WR;
            end else if (read_want) begin
                gnt = GNT_RD;
            end
        end
    end

    assign ram_wren    = (gnt == GNT_WR);
    assign ram_addr    = (gnt == GNT_WR) ? wr_ptr : rd_ptr;
    assign ram_data_in = in_data;

    assign out_valid = (ob_cnt != 2'd0);
    assign pop       = out_valid && out_ready;
    assign count     = ram_count + CW'(rd_inflight) + CW'(ob_cnt);
    assign empty     = (count == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            ram_count   <= '0;
            rd_inflight <= '0;
            pref        <= PREF_WR;
        end else begin
            if (gnt == GNT_WR) begin
                wr_ptr <= AW'(ptr_inc(int'(wr_ptr), DEPTH));
            end
            if (gnt == GNT_RD) begin
                rd_ptr <= AW'(ptr_inc(int'(rd_ptr), DEPTH));
            end
            ram_count   <= ram_count + CW'(gnt == GNT_WR) - CW'(gnt == GNT_RD);
            rd_inflight <= (gnt == GNT_RD);
            // Alternate the winner only when both sides actually compete.
            if (contended) begin
                pref <= (pref == PREF_WR) ? PREF_RD : PREF_WR;
            end
        end
    end

    fifo_sig_ram_obuf #(
        .WIDTH (WIDTH)
    ) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_inflight[0]),
        .push_data (ram_data_out),
        .pop       (pop),
        .head      (out_data),
        .cnt       (ob_cnt)
    );

endmodule

// File: tb/tb_fifo_sig_ram_ctrl.sv
// Bench for fifo_sig_ram_ctrl (DEPTH=5) with a behavioural single-port RAM
// whose read data is only meaningful in the cycle after the read.
module tb_fifo_sig_ram_ctrl;

    localparam int W     = 8;
    localparam int DEPTH = 5;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 4);
    localparam int CAP   = DEPTH + 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          ram_wren;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_data_in;
    logic [W-1:0]  ram_data_out;

    fifo_sig_ram_ctrl #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .ram_wren     (ram_wren),
        .ram_addr     (ram_addr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Single-port RAM; read data is scrambled after a write cycle.
    logic [W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_addr] <= ram_data_in;
            ram_data_out  <= W'($urandom);
        end else begin
            ram_data_out  <= mem[ram_addr];
        end
    end

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           exp_wa = 0;
    logic         stall_prev = 1'b0;
    logic         acc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check just after, update model.
    task automatic cycle(input logic iv, input logic [W-1:0] d, input logic ordy);
        int sz;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        sz = exp_q.size();
        chk("count", int'(count), sz);
        chk("count_cap", int'(count <= CW'(CAP)), 1);
        chk("empty", int'(empty), int'(sz == 0));
        if (sz == 0) chk("out_valid_empty", int'(out_valid), 0);
        if (sz < DEPTH) chk("full_low", int'(full), 0);
        if (sz == CAP) chk("full_high", int'(full), 1);
        if (full) chk("in_ready_full", int'(in_ready), 0);
        chk("wren_grant", int'(ram_wren), int'(in_valid && in_ready));
        if (ram_wren) begin
            chk("wr_addr", int'(ram_addr), exp_wa);
            chk("wr_data", int'(ram_data_in), int'(in_data));
            exp_wa = (exp_wa + 1) % DEPTH;
        end
        if (in_valid && !in_ready && !full) begin
            chk("write_fairness", int'(stall_prev), 0);
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (out_valid && out_ready && sz != 0) begin
            chk("out_data", int'(out_data), int'(exp_q.pop_front()));
        end
        acc = in_valid && in_ready;
        if (acc) exp_q.push_back(in_data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hEE;
        out_ready = 1'b1;
        #1;
        chk("rst_hold_in_ready", int'(in_ready), 0);
        chk("rst_hold_wren", int'(ram_wren), 0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        exp_wa     = 0;
        stall_prev = 1'b0;
    endtask

    task automatic chk_reset_state();
        cycle(1'b0, '0, 1'b0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_in_ready", int'(in_ready), 1);
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || count != '0) && n < 60) begin
            cycle(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_count", int'(count), 0);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic stream(input int n, input int iv_pct, input int or_pct,
                          input int budget, output int used);
        int           sent = 0;
        logic [W-1:0] d;
        logic         iv;
        logic         ordy;
        used = 0;
        d    = W'($urandom);
        while (sent < n && used < budget) begin
            iv   = ($urandom_range(0, 99) < iv_pct);
            ordy = ($urandom_range(0, 99) < or_pct);
            cycle(iv, d, ordy);
            if (acc) begin
                sent++;
                d = W'($urandom);
            end
            used++;
        end
        chk("stream_sent", sent, n);
    endtask

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          e_ird;
        logic          e_wren;
        logic [AW-1:0] e_addr;
        logic          e_ov;
        logic [W-1:0]  e_od;
        int            e_cnt;
    } vec_t;

    vec_t vt[5];

    initial begin
        int sent;
        int n;
        int used;

        vt[0] = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 0};
        vt[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 1};
        vt[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 1};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b1, 8'hA5, 1};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 8'h00, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        do_reset();
        chk_reset_state();

        // single word latency table
        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].iv, vt[i].d, vt[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(vt[i].e_ird));
            chk($sformatf("vec%0d_wren", i), int'(ram_wren), int'(vt[i].e_wren));
            chk($sformatf("vec%0d_addr", i), int'(ram_addr), int'(vt[i].e_addr));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(vt[i].e_ov));
            chk($sformatf("vec%0d_count", i), int'(count), vt[i].e_cnt);
            if (vt[i].e_ov) chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(vt[i].e_od));
        end

        // fill to total capacity, then drain in order
        sent = 0;
        n    = 0;
        while (sent < CAP && n < 40) begin
            cycle(1'b1, W'(sent), 1'b0);
            if (acc) sent++;
            n++;
        end
        chk("fill_accepted", sent, CAP);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, 1'b0);
        chk("fill_in_ready", int'(in_ready), 0);
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(count), CAP);
        drain();

        // backpressure hold
        sent = 0;
        n    = 0;
        while (sent < 4 && n < 30) begin
            cycle(1'b1, W'($urandom), 1'b0);
            if (acc) sent++;
            n++;
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, '0, 1'b0);
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(exp_q[0]));
        end
        drain();

        // contention: continuous push and pop
        stream(200, 100, 100, 1000, used);
        chk("contention_rate", int'(used <= 2 * 200 + 10), 1);
        drain();

        // random traffic across many pointer wraps
        stream(50, 70, 50, 2000, used);
        drain();
        stream(100, 50, 80, 2000, used);
        drain();

        // reset while a read is in flight and the output buffer holds two
        sent = 0;
        n    = 0;
        while (sent < 3 && n < 20) begin
            cycle(1'b1, W'(8'h50 + sent), 1'b0);
            if (acc) sent++;
            n++;
        end
        cycle(1'b0, '0, 1'b0);
        cycle(1'b0, '0, 1'b0);
        chk("mid_valid_before_reset", int'(out_valid), 1);
        do_reset();
        chk_reset_state();
        cycle(1'b1, 8'h3C, 1'b0);
        chk("mid_push", int'(acc), 1);
        n = 0;
        while (!out_valid && n < 10) begin
            cycle(1'b0, '0, 1'b0);
            n++;
        end
        chk("mid_first_valid", int'(out_valid), 1);
        chk("mid_first_data", int'(out_data), 'h3C);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach its end within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
